program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 19 +
 rtl/program_loader_release_timer.sv | 40 ++++
 rtl/program_loader.sv | 179 +++++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared processor constants and types for the instruction-memory program loader.
// Holds default widths, the core-release hold length and the loader state encoding.
// No ports; imported by program_loader and release_timer.
package program_loader_pkg;

    localparam int PL_INSTR_LEN      = 16;  // instruction word width
    localparam int PL_MEM_AW         = 5;   // instruction-memory address width (32 words)
    localparam int PL_RELEASE_CYCLES = 2;   // cycles core reset is held after a good load

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } pl_state_e;

endpackage

// File: rtl/program_loader_release_timer.sv
// Purpose: loadable down-counter with zero flag that times the core-release hold.
// Latency: load takes effect at the next edge; zero_o is a direct decode of the count register.
// Backpressure: none; dec_i is ignored once the count reaches zero.
// Ports: clk/rst (async active-low), load_i + load_val_i preset, dec_i decrement, zero_o flag.
module release_timer
    import program_loader_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/program_loader.sv
// Purpose: streams a program into instruction memory, verifies its checksum, then releases the core.
// Latency: each accepted word is written one cycle after its transfer; core released 1 + RELEASE_CYCLES cycles after the last word.
// Backpressure: in_ready is high only in LOAD while words remain; start is ignored while busy.
// Ports: start/prog_len/chk_in load request, in_valid/in_ready/in_data word stream,
//        im_wr_* memory write port, core_rst_n core reset, busy/done/err status.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INSTRUCTION_LEN      = PL_INSTR_LEN,
    parameter int INSTRUCTION_MEM_SIZE = PL_MEM_AW,
    parameter int RELEASE_CYCLES       = PL_RELEASE_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [INSTRUCTION_MEM_SIZE:0]   prog_len,
    input  logic [INSTRUCTION_LEN-1:0]      chk_in,
    input  logic                            in_valid,
    input  logic [INSTRUCTION_LEN-1:0]      in_data,
    output logic                            in_ready,
    output logic                            im_wr_en,
    output logic [INSTRUCTION_MEM_SIZE-1:0] im_wr_addr,
    output logic [INSTRUCTION_LEN-1:0]      im_wr_data,
    output logic                            core_rst_n,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int AW = INSTRUCTION_MEM_SIZE;
    localparam int CW = INSTRUCTION_MEM_SIZE + 1;   // count can reach 2**AW
    localparam int IL = INSTRUCTION_LEN;
    localparam int TW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CW-1:0] MAX_WORDS = CW'(1 << AW);

    pl_state_e     state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [IL-1:0] chk_q, chk_d;
    logic [CW-1:0] count_q, count_d;
    logic [IL-1:0] sum_q, sum_d;
    logic          in_ready_q, in_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [IL-1:0] wr_data_q, wr_data_d;
    logic          core_rst_n_q, core_rst_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          start_ok;
    logic [CW-1:0] count_inc;
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_zero;

    assign start_ok  = (prog_len != '0) && (prog_len <= MAX_WORDS);
    assign count_inc = count_q + CW'(1);

    // Timer is preset to RELEASE_CYCLES-1 on entry so RELEASE lasts exactly RELEASE_CYCLES cycles.
    release_timer #(
        .WIDTH (TW)
    ) u_release_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (TW'(RELEASE_CYCLES - 1)),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        chk_d     = chk_q;
        count_d   = count_q;
        sum_d     = sum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    if (start_ok) begin
                        state_d = ST_LOAD;
                        len_d   = prog_len;
                        chk_d   = chk_in;
                        count_d = '0;
                        sum_d   = '0;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_LOAD: begin
                // in_ready_q already encodes count < len, so the address can never pass len-1.
                if (in_valid && in_ready_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[AW-1:0];
                    wr_data_d = in_data;
                    count_d   = count_inc;
                    sum_d     = sum_q + in_data;
                    if (count_inc == len_q) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (sum_q == chk_q) begin
                    state_d  = ST_RELEASE;
                    tmr_load = 1'b1;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_RELEASE: begin
                if (tmr_zero) begin
                    state_d = ST_RUN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state, so they line up with state_q.
        in_ready_d   = (state_d == ST_LOAD) && (count_d < len_d);
        core_rst_n_d = (state_d == ST_RUN);
        done_d       = (state_d == ST_RUN);
        err_d        = (state_d == ST_ERROR);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_CHECK) || (state_d == ST_RELEASE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            chk_q        <= '0;
            count_q      <= '0;
            sum_q        <= '0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            chk_q        <= chk_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign im_wr_en   = wr_en_q;
    assign im_wr_addr = wr_addr_q;
    assign im_wr_data = wr_data_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed loads checked against a write-list / checksum model.
// Latency expectations: writes one cycle after transfer; core release 1 + 2 cycles after the last word.
// Stimulus driven on falling edges; outputs sampled on falling edges.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  prog_len;
    logic [15:0] chk_in;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        im_wr_en;
    logic [4:0]  im_wr_addr;
    logic [15:0] im_wr_data;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prog_len   (prog_len),
        .chk_in     (chk_in),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_wr_en   (im_wr_en),
        .im_wr_addr (im_wr_addr),
        .im_wr_data (im_wr_data),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t         expq[$];
    logic [15:0] prog [32];
    int          n_vec = 0;
    int          n_err = 0;
    int          writes_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: checksum is the plain sum of the program words, truncated to 16 bits.
    function automatic logic [15:0] model_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(prog[i]);
        return 16'(s);
    endfunction

    // Every write strobe must match the next expected (address, word) pair of the program.
    always @(negedge clk) begin
        if (im_wr_en === 1'b1) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0h, required no write", im_wr_addr, im_wr_data);
            end else begin
                wr_t e;
                e = expq.pop_front();
                chk("wr_addr", 32'(im_wr_addr), 32'(e.addr));
                chk("wr_data", 32'(im_wr_data), 32'(e.data));
                writes_seen++;
            end
        end
        chk("core_rel_vs_done", 32'(core_rst_n), 32'(done));
        if (busy === 1'b1) chk("busy_excl_status", 32'(done | err), 32'd0);
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   0);
        chk({tag, "_wr_en"},      32'(im_wr_en),   0);
        chk({tag, "_wr_addr"},    32'(im_wr_addr), 0);
        chk({tag, "_wr_data"},    32'(im_wr_data), 0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
        chk({tag, "_busy"},       32'(busy),       0);
        chk({tag, "_done"},       32'(done),       0);
        chk({tag, "_err"},        32'(err),        0);
    endtask

    // Called on a falling edge; returns on a falling edge with reset released.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1 check_reset_vals("rst");
        expq.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    // Issues start, then streams words until n accepted or stop_after reached.
    task automatic run_load(input int n, input logic [15:0] chk_v, input bit gaps,
                            input int stop_after, input bit poke);
        int  i = 0;
        int  cyc = 0;
        bit  take;
        start    = 1'b1;
        prog_len = 6'(n);
        chk_in   = chk_v;
        for (int k = 0; k < n; k++) begin
            wr_t e;
            e.addr = k;
            e.data = prog[k];
            expq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("start_busy",     32'(busy),       1);
        chk("start_ready",    32'(in_ready),   1);
        chk("start_core_rst", 32'(core_rst_n), 0);
        chk("start_done",     32'(done),       0);
        chk("start_err",      32'(err),        0);
        while (i < n && i < stop_after && cyc < 300) begin
            in_valid = gaps ? ~cyc[0] : 1'b1;
            in_data  = in_valid ? prog[i] : 16'hDEAD;
            if (poke) begin
                start = (cyc == 1);
                if (cyc == 1) prog_len = 6'd0;
            end
            take = in_valid && in_ready;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            chk("wr_strobe", 32'(im_wr_en), 32'(take));
            if (take) i++;
        end
        in_valid = 1'b0;
        if (cyc >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL feed_timeout: got %0d words, required %0d", i, n);
        end
    endtask

    // Called on the falling edge after the last transfer.
    task automatic finish_load(input int n, input bit good, input int ws0);
        chk("ready_drop", 32'(in_ready), 0);
        chk("check_busy", 32'(busy),     1);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        @(negedge clk);
        in_valid = 1'b0;
        if (good) begin
            chk("rel1_busy",     32'(busy),       1);
            chk("rel1_core_rst", 32'(core_rst_n), 0);
            @(negedge clk);
            chk("rel2_busy",     32'(busy),       1);
            chk("rel2_core_rst", 32'(core_rst_n), 0);
            @(negedge clk);
            chk("run_core_rst",  32'(core_rst_n), 1);
            chk("run_done",      32'(done),       1);
            chk("run_busy",      32'(busy),       0);
            chk("run_err",       32'(err),        0);
        end else begin
            chk("bad_err",      32'(err),        1);
            chk("bad_core_rst", 32'(core_rst_n), 0);
            chk("bad_busy",     32'(busy),       0);
            chk("bad_done",     32'(done),       0);
        end
        chk("write_count", 32'(writes_seen - ws0), 32'(n));
        chk("writes_left", 32'(expq.size()),       0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ws0;
        rst = 1'b0; start = 1'b0; prog_len = '0; chk_in = '0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("por");
        #2 rst = 1'b1;
        @(negedge clk);

        // Good 3-word load from IDLE.
        prog[0] = 16'h1234; prog[1] = 16'h0001; prog[2] = 16'h0FF0;
        chk("model_sum_a", 32'(model_sum(3)), 32'h2225);
        ws0 = writes_seen;
        run_load(3, 16'h2225, 1'b0, 99, 1'b0);
        finish_load(3, model_sum(3) == 16'h2225, ws0);

        // Same words, wrong checksum, started from RUN; a bad start mid-load is ignored.
        ws0 = writes_seen;
        run_load(3, 16'h0000, 1'b0, 99, 1'b1);
        finish_load(3, model_sum(3) == 16'h0000, ws0);

        // Illegal lengths from IDLE and from ERROR.
        do_reset();
        ws0 = writes_seen;
        start = 1'b1; prog_len = 6'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_err",   32'(err),      1);
        chk("len0_busy",  32'(busy),     0);
        chk("len0_ready", 32'(in_ready), 0);
        do_reset();
        start = 1'b1; prog_len = 6'd33;
        @(negedge clk);
        start = 1'b0;
        chk("len33_err",  32'(err),  1);
        chk("len33_busy", 32'(busy), 0);
        start = 1'b1; prog_len = 6'd33;
        @(negedge clk);
        start = 1'b0;
        chk("len33_again_err", 32'(err), 1);
        @(negedge clk);
        chk("bad_len_writes", 32'(writes_seen - ws0), 0);

        // Full 32-word load with gaps, from ERROR; sum wraps past 16 bits.
        for (int k = 0; k < 32; k++) prog[k] = 16'h0F00 + 16'(k);
        chk("model_sum_c", 32'(model_sum(32)), 32'h0000E1F0);
        ws0 = writes_seen;
        run_load(32, model_sum(32), 1'b1, 99, 1'b0);
        finish_load(32, 1'b1, ws0);

        // Reset after the 2nd of 5 words aborts the load.
        for (int k = 0; k < 5; k++) prog[k] = 16'hA000 + 16'(k);
        ws0 = writes_seen;
        run_load(5, model_sum(5), 1'b0, 2, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk("abort_wr_en", 32'(im_wr_en), 0);
            chk("abort_ready", 32'(in_ready), 0);
            chk("abort_busy",  32'(busy),     0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("abort_writes", 32'(writes_seen - ws0), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
